// File: rtl/tt_pkg.sv
// tt_pkg: shared constants and types for the truth-table sweep block.
// Pattern width, signature width, settle counter width and FSM states.
package tt_pkg;

  localparam int N_IN     = 7;
  localparam int TT_W     = 2 ** N_IN;
  localparam int SETTLE_W = 4;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef logic [TT_W-1:0] sig_t;

endpackage

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: walks every input pattern of a combinational function,
// captures its truth table and ones count, and compares against a signature.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  sig_t            expected,
  output logic [N_IN-1:0] x,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output sig_t            tt,
  output logic [N_IN:0]   ones,
  output logic            tt_valid,
  output logic            match
);

  localparam logic [SETTLE_W-1:0] S_LAST = SETTLE_W'(SETTLE);
  localparam logic [N_IN-1:0]     X_LAST = N_IN'(TT_W - 1);

  state_t              state;
  logic [SETTLE_W-1:0] s;
  sig_t                exp_q;

  // Sweep sequencer: hold each pattern S_LAST+1 cycles, sample on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      s        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= '0;
      ones     <= '0;
      tt_valid <= 1'b0;
      exp_q    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            tt       <= '0;
            ones     <= '0;
            tt_valid <= 1'b0;
            exp_q    <= expected;
            x        <= '0;
            s        <= '0;
          end
        end
        RUN: begin
          if (s == S_LAST) begin
            tt[x] <= f_in;
            ones  <= ones + {{N_IN{1'b0}}, f_in};
            s     <= '0;
            x     <= x + N_IN'(1);
            if (x == X_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tt_valid <= 1'b1;
              done     <= 1'b1;
            end
          end else begin
            s <= s + SETTLE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Signature compare only means something once a sweep is complete.
  assign match = tt_valid & (tt == exp_q);

endmodule
